// File: rtl/host_write_buffer.sv
// Page-aggregating write FIFO: buffers host words and releases them to flash in page bursts.
// Optional macro HOST_WRITE_BUFFER_PARITY_EN adds per-entry even parity and a flash_parity output.
module host_write_buffer #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 16,
   parameter int PAGE_WORDS = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_ready,
   input  logic                       flush,
   output logic                       flash_valid,
   output logic [DATA_W-1:0]          flash_data,
   output logic                       flash_last,
   input  logic                       flash_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
`ifdef HOST_WRITE_BUFFER_PARITY_EN
   ,
   output logic                       flash_parity
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef HOST_WRITE_BUFFER_PARITY_EN
   localparam int EW = DATA_W + 1;
`else
   localparam int EW = DATA_W;
`endif

   typedef enum logic {IDLE, BURST} state_t;

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] wr_entry, head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt, burst_len, burst_len_nxt, beat, beat_nxt;
   state_t        state, state_nxt;
   logic          flush_pend, flush_pend_nxt;
   logic          wr_en, rd_en;

`ifdef HOST_WRITE_BUFFER_PARITY_EN
   assign wr_entry     = {^wr_data, wr_data};
   assign flash_parity = head[DATA_W];
`else
   assign wr_entry = wr_data;
`endif

   // Show-ahead head; memory is reset so the head reads zero out of reset.
   assign head        = mem[rd_ptr];
   assign flash_data  = head[DATA_W-1:0];
   assign count       = cnt;
   assign wr_ready    = (cnt < CW'(DEPTH));
   assign flash_valid = (state == BURST);
   assign flash_last  = flash_valid && (beat == burst_len - CW'(1));
   assign busy        = flash_valid || flush_pend;
   assign wr_en       = wr_valid && wr_ready;
   assign rd_en       = flash_valid && flash_ready;

   always_comb begin
      state_nxt     = state;
      burst_len_nxt = burst_len;
      beat_nxt      = beat;
      case (state)
         IDLE: begin
            if (cnt >= CW'(PAGE_WORDS) || (flush_pend && cnt != '0)) begin
               state_nxt     = BURST;
               burst_len_nxt = (cnt >= CW'(PAGE_WORDS)) ? CW'(PAGE_WORDS) : cnt;
               beat_nxt      = '0;
            end
         end
         BURST: begin
            if (rd_en) begin
               if (flash_last) state_nxt = IDLE;
               else            beat_nxt  = beat + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A new pulse wins over the clearing condition.
      flush_pend_nxt = flush || (flush_pend && !(state == IDLE && cnt == '0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         burst_len  <= '0;
         beat       <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         burst_len  <= burst_len_nxt;
         beat       <= beat_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

endmodule

// File: tb/tb_host_write_buffer.sv
// Randomized and directed bench for host_write_buffer against a queue-based reference model.
module tb_host_write_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int PW     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid, flush, flash_ready;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready, flash_valid, flash_last, busy;
   logic [DATA_W-1:0] flash_data;
   logic [$clog2(DEPTH):0] count;
`ifdef HOST_WRITE_BUFFER_PARITY_EN
   logic              flash_parity;
`endif

   host_write_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PAGE_WORDS(PW)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .flush(flush),
      .flash_valid(flash_valid), .flash_data(flash_data), .flash_last(flash_last),
      .flash_ready(flash_ready),
      .count(count), .busy(busy)
`ifdef HOST_WRITE_BUFFER_PARITY_EN
      , .flash_parity(flash_parity)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int dut_beats = 0;

   // Reference model: buffered words, whether a burst is running, beats left in it, flush pending.
   logic [DATA_W-1:0] q[$];
   bit m_burst, m_fp;
   int m_left;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      int sz;
      bit wr, rd, fp_n;
      if (rst) begin
         q.delete();
         m_burst = 0;
         m_fp    = 0;
         m_left  = 0;
      end else begin
         sz   = q.size();
         wr   = wr_valid && (sz < DEPTH);
         rd   = m_burst && flash_ready;
         fp_n = flush || (m_fp && !(!m_burst && sz == 0));
         if (m_burst) begin
            if (rd) begin
               m_left--;
               if (m_left == 0) m_burst = 0;
            end
         end else if (sz >= PW || (m_fp && sz > 0)) begin
            m_burst = 1;
            m_left  = (sz < PW) ? sz : PW;
         end
         if (rd) void'(q.pop_front());
         if (wr) q.push_back(wr_data);
         m_fp = fp_n;
      end
   end

   always @(posedge clk) if (!rst && flash_valid && flash_ready) dut_beats++;

   task automatic check_outs();
      chk("count", count, q.size());
      chk("wr_ready", wr_ready, q.size() < DEPTH);
      chk("flash_valid", flash_valid, m_burst);
      chk("flash_last", flash_last, m_burst && m_left == 1);
      chk("busy", busy, m_burst || m_fp);
      if (m_burst) begin
         chk("flash_data", flash_data, q[0]);
`ifdef HOST_WRITE_BUFFER_PARITY_EN
         chk("flash_parity", flash_parity, ^q[0]);
`endif
      end
   endtask

   task automatic cyc(input logic wv, input logic [DATA_W-1:0] wd, input logic fl, input logic fr);
      wr_valid    = wv;
      wr_data     = wd;
      flush       = fl;
      flash_ready = fr;
      @(posedge clk);
      @(negedge clk);
      wr_valid = 1'b0;
      flush    = 1'b0;
      check_outs();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base, idx, guard;
      logic [DATA_W-1:0] wd;
      rst = 1'b1; wr_valid = 0; wr_data = '0; flush = 0; flash_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_valid", flash_valid, 0);
      chk("rst_last", flash_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", flash_data, 0);
      rst = 1'b0;
      cyc(0, '0, 0, 1);

      // Full page, back to back, sink always ready.
      for (int i = 0; i < 8; i++) cyc(1, 32'h1000_0000 + DATA_W'(i), 0, 1);
      chk("t1_valid_early", flash_valid, 0);
      cyc(0, '0, 0, 1);
      chk("t1_valid_lat", flash_valid, 1);
      chk("t1_first", flash_data, 32'h1000_0000);
      repeat (10) cyc(0, '0, 0, 1);
      chk("t1_count_end", count, 0);

      // Partial page forced out by flush, then flush on empty.
      cyc(1, 32'hA, 0, 1);
      cyc(1, 32'hB, 0, 1);
      cyc(1, 32'hC, 0, 1);
      cyc(0, '0, 1, 1);
      repeat (8) cyc(0, '0, 0, 1);
      chk("t2_busy_end", busy, 0);
      cyc(0, '0, 1, 1);
      chk("t2_busy_pulse", busy, 1);
      cyc(0, '0, 0, 1);
      chk("t2_busy_clear", busy, 0);
      chk("t2_no_valid", flash_valid, 0);

      // Fill under backpressure, overflow attempt, then drain.
      for (int i = 0; i < 16; i++) cyc(1, 32'h300 + DATA_W'(i), 0, 0);
      cyc(1, 32'hDEAD_BEEF, 0, 0);
      chk("t3_full_count", count, 16);
      chk("t3_full_ready", wr_ready, 0);
      repeat (3) cyc(0, '0, 0, 0);
      chk("t3_hold_data", flash_data, 32'h300);
      chk("t3_hold_last", flash_last, 0);
      base = dut_beats;
      repeat (25) cyc(0, '0, 0, 1);
      chk("t3_beats", dut_beats - base, 16);
      chk("t3_count_end", count, 0);

      // Random traffic across pointer wrap.
      base  = dut_beats;
      idx   = 0;
      guard = 0;
      while (idx < 40 && guard < 2000) begin
         wd = $urandom;
         if ($urandom_range(1, 0) == 1) begin
            if (q.size() < DEPTH) idx++;
            cyc(1, wd, 0, $urandom_range(1, 0) == 1);
         end else begin
            cyc(0, wd, 0, $urandom_range(1, 0) == 1);
         end
         guard++;
      end
      chk("t4_guard", guard < 2000, 1);
      cyc(0, '0, 1, 1);
      repeat (40) cyc(0, '0, 0, 1);
      chk("t4_beats", dut_beats - base, 40);
      chk("t4_count_end", count, 0);

      // Reset in the middle of a burst.
      for (int i = 0; i < 8; i++) cyc(1, 32'h500 + DATA_W'(i), 0, 0);
      base  = dut_beats;
      guard = 0;
      while (dut_beats - base < 3 && guard < 30) begin
         cyc(0, '0, 0, 1);
         guard++;
      end
      chk("t5_three_beats", dut_beats - base, 3);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", flash_valid, 0);
      chk("t5_rst_count", count, 0);
      chk("t5_rst_busy", busy, 0);
      @(negedge clk);
      rst  = 1'b0;
      base = dut_beats;
      repeat (10) cyc(0, '0, 0, 1);
      chk("t5_no_beats", dut_beats - base, 0);

`ifdef HOST_WRITE_BUFFER_PARITY_EN
      cyc(1, 32'h1, 0, 1);
      cyc(1, 32'h3, 0, 1);
      for (int i = 0; i < 6; i++) cyc(1, 32'h700 + DATA_W'(i), 0, 1);
      cyc(0, '0, 0, 1);
      chk("t6_par_data0", flash_data, 32'h1);
      chk("t6_par0", flash_parity, 1);
      cyc(0, '0, 0, 1);
      chk("t6_par_data1", flash_data, 32'h3);
      chk("t6_par1", flash_parity, 0);
      repeat (10) cyc(0, '0, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
